// File: rtl/layer_output_reader_pkg.sv
// Shared layer-I/O definitions: element/packing defaults, bus widths and the
// drain sequencer state encoding.
package layer_output_reader_pkg;

    localparam int DEPTH_DEF  = 16384;
    localparam int DATA_W_DEF = 4;
    localparam int PACK_DEF   = 8;
    localparam int ADDR_W     = 32;
    localparam int CHK_W      = 18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DONE,
        ST_READ,
        ST_FLUSH,
        ST_FINISH
    } state_t;

    // Width of a counter that must hold the values 0..pack inclusive.
    function automatic int fill_w(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/layer_output_reader_packer.sv
// Collects PACK signed elements into one word, element 0 in the low bits.
// A completing element can go straight to the output register when it is free.
module nibble_packer
    import layer_output_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PACK   = PACK_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_last,
    input  logic                          out_accept,
    output logic [fill_w(PACK)-1:0]       fill,
    output logic                          word_load,
    output logic [DATA_W*PACK-1:0]        word,
    output logic                          word_last
);

    localparam int WORD_W = DATA_W * PACK;
    localparam int FILL_W = fill_w(PACK);

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shifted;
    logic              full;
    logic              completing;
    logic              last_held;

    // New elements enter at the top so the first one ends up in the low bits.
    assign shifted    = {in_data, shreg[WORD_W-1:DATA_W]};
    assign full       = (fill == FILL_W'(PACK));
    assign completing = in_valid && (fill == FILL_W'(PACK - 1));
    assign word_load  = (full || completing) && out_accept;
    assign word       = full ? shreg : shifted;
    assign word_last  = full ? last_held : in_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill      <= '0;
            last_held <= 1'b0;
        end else if (word_load) begin
            fill      <= '0;
            last_held <= 1'b0;
        end else if (in_valid) begin
            fill      <= fill + FILL_W'(1);
            last_held <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && !word_load) begin
            shreg <= shifted;
        end
    end

endmodule

// File: rtl/layer_output_reader.sv
// Drains a conv layer's output buffer: issues element reads, packs them into
// words for a valid/ready stream and keeps a signed running checksum.
module layer_output_reader
    import layer_output_reader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int PACK   = PACK_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     layer_done,
    output logic [ADDR_W-1:0]        read_addr,
    input  logic [DATA_W-1:0]        read_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W*PACK-1:0]   m_data,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done,
    output logic [CHK_W-1:0]         checksum
);

    localparam int WORD_W = DATA_W * PACK;
    localparam int FILL_W = fill_w(PACK);

    function automatic logic signed [CHK_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(CHK_W - DATA_W){v[DATA_W-1]}}, v};
    endfunction

    state_t                   state;
    logic [ADDR_W-1:0]        next_addr;
    logic [ADDR_W-1:0]        last_addr;
    logic                     vld_p0;
    logic                     last_p0;
    logic                     vld_p1;
    logic                     last_p1;
    logic [FILL_W-1:0]        fill;
    logic [FILL_W:0]          occupancy;
    logic                     out_accept;
    logic                     word_load;
    logic [WORD_W-1:0]        word;
    logic                     word_last;
    logic signed [CHK_W-1:0]  sum;

    // Issue stage: a read goes out only if its element is guaranteed a slot.
    assign occupancy  = {1'b0, fill} + {{FILL_W{1'b0}}, vld_p1};
    assign vld_p0     = (state == ST_READ) && (occupancy < (FILL_W + 1)'(PACK));
    assign last_p0    = (next_addr == ADDR_W'(DEPTH - 1));
    assign read_addr  = vld_p0 ? next_addr : last_addr;
    assign out_accept = !m_valid || m_ready;
    assign checksum   = sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            next_addr <= '0;
            last_addr <= '0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
        end else begin
            // Return stage: read_data belongs to the read issued last cycle.
            vld_p1  <= vld_p0;
            last_p1 <= vld_p0 && last_p0;
            if (vld_p1) begin
                sum <= sum + sext(read_data);
            end
            if (vld_p0) begin
                last_addr <= next_addr;
                next_addr <= next_addr + ADDR_W'(1);
            end
            case (state)
                ST_IDLE, ST_FINISH: begin
                    if (start) begin
                        state     <= ST_WAIT_DONE;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        sum       <= '0;
                        next_addr <= '0;
                        last_addr <= '0;
                    end
                end
                ST_WAIT_DONE: begin
                    if (layer_done) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (vld_p0 && last_p0) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (m_valid && m_ready && m_last) begin
                        state <= ST_FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    nibble_packer #(
        .DATA_W (DATA_W),
        .PACK   (PACK)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (vld_p1),
        .in_data    (read_data),
        .in_last    (last_p1),
        .out_accept (out_accept),
        .fill       (fill),
        .word_load  (word_load),
        .word       (word),
        .word_last  (word_last)
    );

    // Output register: holds its word unchanged until the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
        end else if (word_load) begin
            m_valid <= 1'b1;
            m_data  <= word;
            m_last  <= word_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_output_reader.sv
// Bench for layer_output_reader: a buffer model with one-cycle read latency,
// a stream monitor, and per-scenario tasks checked against a packing model.
module tb_layer_output_reader;

    localparam int DEPTH  = 16384;
    localparam int DATA_W = 4;
    localparam int PACK   = 8;
    localparam int WORDS  = DEPTH / PACK;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        layer_done;
    logic [31:0] read_addr;
    logic [3:0]  read_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
    logic [17:0] checksum;

    int vectors = 0;
    int miscompares = 0;
    bit neg8 = 1'b0;

    logic [31:0] got_words[$];
    bit          got_last[$];
    int          cyc = 0;
    int          hs_cyc = -1;
    int          done_cyc = -2;
    int          stall_bad = 0;
    logic [31:0] max_addr = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    layer_output_reader #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PACK(PACK)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .layer_done (layer_done),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] elem(input int a);
        return neg8 ? 4'b1000 : 4'(a & 15);
    endfunction

    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] w;
        for (int i = 0; i < PACK; i++) w[DATA_W*i +: DATA_W] = elem(PACK*k + i);
        return w;
    endfunction

    function automatic int exp_checksum();
        int s = 0;
        for (int a = 0; a < DEPTH; a++) s += int'($signed(elem(a)));
        return s;
    endfunction

    // Buffer: data for the address presented this cycle is valid next cycle.
    always @(posedge clk) read_data <= elem(int'(read_addr));

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
                stall_bad++;
            if (m_valid && m_ready) begin
                got_words.push_back(m_data);
                got_last.push_back(m_last);
                if (m_last) hs_cyc = cyc + 1;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (read_addr > max_addr) max_addr = read_addr;
        end
    end

    task automatic clear_monitor();
        got_words.delete();
        got_last.delete();
        stall_bad = 0;
        max_addr = '0;
        hs_cyc = -1;
        done_cyc = -2;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_monitor();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input bit rnd_ready, input int pulse_at,
                               output int cycles, output bit timed_out);
        cycles = 0;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            cycles++;
            start = (c == pulse_at);
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
            if (done) begin
                timed_out = 1'b0;
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic scan_words(output int nbad, output int first_bad);
        nbad = 0;
        first_bad = -1;
        for (int k = 0; k < got_words.size() && k < WORDS; k++) begin
            if (got_words[k] !== exp_word(k) || got_last[k] !== (k == WORDS - 1)) begin
                nbad++;
                if (first_bad < 0) first_bad = k;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (read_addr !== 32'd0) begin miscompares++; $display("FAIL reset_read_addr: got %0h want 0", read_addr); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        vectors++; if (m_last !== 1'b0) begin miscompares++; $display("FAIL reset_m_last: got %b want 0", m_last); end
        vectors++; if (m_data !== 32'd0) begin miscompares++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (checksum !== 18'd0) begin miscompares++; $display("FAIL reset_checksum: got %0h want 0", checksum); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        clear_monitor();
    endtask

    task automatic test_drain_ready_start_in_read();
        int cycles, nbad, first_bad;
        bit to;
        neg8 = 1'b0;
        layer_done = 1'b1;
        m_ready = 1'b1;
        pulse_start();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL d1_busy_after_start: got %b want 1", busy); end
        run_to_done(WORDS * 20, 1'b0, int'($urandom_range(100, 15000)), cycles, to);
        vectors++; if (to) begin miscompares++; $display("FAIL d1_timeout: got no done want done"); end
        vectors++; if (got_words.size() !== WORDS) begin miscompares++; $display("FAIL d1_word_count: got %0d want %0d", got_words.size(), WORDS); end
        scan_words(nbad, first_bad);
        vectors++; if (nbad !== 0) begin miscompares++; $display("FAIL d1_words: got %0d bad words (first %0d) want 0", nbad, first_bad); end
        vectors++; if (got_words.size() > 0 && got_words[0] !== 32'h76543210) begin miscompares++; $display("FAIL d1_word0: got %h want 76543210", got_words[0]); end
        vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL d1_done_busy: got done=%b busy=%b want done=1 busy=0", done, busy); end
        vectors++; if (done_cyc !== hs_cyc) begin miscompares++; $display("FAIL d1_done_timing: got cycle %0d want %0d", done_cyc, hs_cyc); end
        vectors++; if (checksum !== 18'(exp_checksum())) begin miscompares++; $display("FAIL d1_checksum: got %0d want %0d", $signed(checksum), exp_checksum()); end
        vectors++; if (cycles > WORDS * (PACK + 1) + 8) begin miscompares++; $display("FAIL d1_throughput: got %0d cycles want <= %0d", cycles, WORDS * (PACK + 1) + 8); end
        vectors++; if (max_addr > 32'(DEPTH - 1)) begin miscompares++; $display("FAIL d1_max_addr: got %0d want <= %0d", max_addr, DEPTH - 1); end
    endtask

    task automatic test_finish_restart_random_ready();
        int cycles, nbad, first_bad;
        bit to;
        clear_monitor();
        pulse_start();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL d2_done_cleared: got %b want 0", done); end
        vectors++; if (checksum !== 18'd0) begin miscompares++; $display("FAIL d2_checksum_cleared: got %0h want 0", checksum); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL d2_busy: got %b want 1", busy); end
        run_to_done(WORDS * 20, 1'b1, -1, cycles, to);
        vectors++; if (to) begin miscompares++; $display("FAIL d2_timeout: got no done want done"); end
        vectors++; if (got_words.size() !== WORDS) begin miscompares++; $display("FAIL d2_word_count: got %0d want %0d", got_words.size(), WORDS); end
        scan_words(nbad, first_bad);
        vectors++; if (nbad !== 0) begin miscompares++; $display("FAIL d2_words: got %0d bad words (first %0d) want 0", nbad, first_bad); end
        vectors++; if (stall_bad !== 0) begin miscompares++; $display("FAIL d2_stall_stable: got %0d unstable stalls want 0", stall_bad); end
        vectors++; if (max_addr > 32'(DEPTH - 1)) begin miscompares++; $display("FAIL d2_max_addr: got %0d want <= %0d", max_addr, DEPTH - 1); end
        vectors++; if (checksum !== 18'(exp_checksum())) begin miscompares++; $display("FAIL d2_checksum: got %0d want %0d", $signed(checksum), exp_checksum()); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL d2_done: got %b want 1", done); end
    endtask

    task automatic test_wait_then_reset_mid_drain();
        int idle_bad = 0;
        int quiet_bad = 0;
        bit reached = 1'b0;
        apply_reset();
        layer_done = 1'b0;
        m_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (read_addr !== 32'd0 || busy !== 1'b1 || m_valid !== 1'b0 || checksum !== 18'd0) idle_bad++;
        end
        vectors++; if (idle_bad !== 0) begin miscompares++; $display("FAIL wait_idle: got %0d bad cycles want 0", idle_bad); end
        layer_done = 1'b1;
        @(posedge clk); #1;
        vectors++; if (read_addr !== 32'd0) begin miscompares++; $display("FAIL wait_first_addr: got %0d want 0", read_addr); end
        @(posedge clk); #1;
        vectors++; if (read_addr !== 32'd1) begin miscompares++; $display("FAIL wait_second_addr: got %0d want 1", read_addr); end
        layer_done = 1'b0;
        for (int c = 0; c < 1000 * (PACK + 1) + 200; c++) begin
            @(posedge clk); #1;
            if (got_words.size() >= 1000) begin
                reached = 1'b1;
                break;
            end
        end
        vectors++; if (!reached) begin miscompares++; $display("FAIL mid_reach_1000: got %0d words want 1000", got_words.size()); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (read_addr !== 32'd0) begin miscompares++; $display("FAIL mid_reset_read_addr: got %0h want 0", read_addr); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_m_valid: got %b want 0", m_valid); end
        vectors++; if (m_last !== 1'b0) begin miscompares++; $display("FAIL mid_reset_m_last: got %b want 0", m_last); end
        vectors++; if (m_data !== 32'd0) begin miscompares++; $display("FAIL mid_reset_m_data: got %h want 0", m_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_reset_done: got %b want 0", done); end
        vectors++; if (checksum !== 18'd0) begin miscompares++; $display("FAIL mid_reset_checksum: got %0h want 0", checksum); end
        @(posedge clk); #1;
        reset = 1'b0;
        layer_done = 1'b1;
        clear_monitor();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (m_valid !== 1'b0 || busy !== 1'b0) quiet_bad++;
        end
        vectors++; if (quiet_bad !== 0 || got_words.size() !== 0) begin miscompares++; $display("FAIL mid_no_emit: got %0d bad cycles, %0d words want 0", quiet_bad, got_words.size()); end
        pulse_start();
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (got_words.size() >= 1) begin
                reached = 1'b1;
                break;
            end
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL restart_word0: got no word want 76543210");
        end else if (got_words[0] !== exp_word(0)) begin
            miscompares++;
            $display("FAIL restart_word0: got %h want %h", got_words[0], exp_word(0));
        end
    endtask

    task automatic test_all_neg8();
        int cycles, nbad, first_bad;
        bit to;
        apply_reset();
        neg8 = 1'b1;
        layer_done = 1'b1;
        m_ready = 1'b1;
        pulse_start();
        run_to_done(WORDS * 20, 1'b0, -1, cycles, to);
        vectors++; if (to) begin miscompares++; $display("FAIL n8_timeout: got no done want done"); end
        vectors++; if (got_words.size() !== WORDS) begin miscompares++; $display("FAIL n8_word_count: got %0d want %0d", got_words.size(), WORDS); end
        scan_words(nbad, first_bad);
        vectors++; if (nbad !== 0) begin miscompares++; $display("FAIL n8_words: got %0d bad words (first %0d) want 0", nbad, first_bad); end
        vectors++; if (checksum !== 18'(exp_checksum())) begin miscompares++; $display("FAIL n8_checksum: got %0d want %0d", $signed(checksum), exp_checksum()); end
        vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL n8_done_busy: got done=%b busy=%b want done=1 busy=0", done, busy); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        layer_done = 1'b0;
        m_ready = 1'b1;
        test_reset();
        test_drain_ready_start_in_read();
        test_finish_restart_random_ready();
        test_wait_then_reset_mid_drain();
        test_all_neg8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
